regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_sb.sv | 68 ++++++
 tb/tb_regfile_sb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg -- shared constants for the register file / scoreboard slice.
//   REG_DATA_WIDTH : default register width in bits
//   REG_ADDR_WIDTH : default register index width (depth = 2**REG_ADDR_WIDTH)
package regfile_sb_pkg;
   localparam int REG_DATA_WIDTH = 64;
   localparam int REG_ADDR_WIDTH = 5;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per register plus a running count.
// Ports:
//   clk, reset (async, active low)
//   issue_en/issue_rd : marks issue_rd pending at the next edge
//   wb_en/wb_addr     : clears wb_addr pending at the next edge
//   rs_addr           : packed read addresses, NUM_READ x ADDR_WIDTH
//   rs_busy           : per-port pending flag, masked by same-cycle writeback
//   pending_cnt       : number of pending registers (registered)
module regfile_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int NUM_READ   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           issue_en,
   input  logic [ADDR_WIDTH-1:0]          issue_rd,
   input  logic                           wb_en,
   input  logic [ADDR_WIDTH-1:0]          wb_addr,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr,
   output logic [NUM_READ-1:0]            rs_busy,
   output logic [ADDR_WIDTH:0]            pending_cnt
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DEPTH-1:0] r_pending;
   logic [DEPTH-1:0] w_pending_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_set;
   logic             w_clr;
   logic             w_inc;
   logic             w_dec;

   always_comb begin
      w_set         = issue_en && (issue_rd != '0);
      w_clr         = wb_en && (wb_addr != '0);
      w_pending_nxt = r_pending;
      // Set is applied after clear so a new producer supersedes the old one.
      if (w_clr) w_pending_nxt[wb_addr]  = 1'b0;
      if (w_set) w_pending_nxt[issue_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
      // Count only real bit transitions; a clear that loses to a set on the
      // same address is not a transition.
      w_inc = w_set && !r_pending[issue_rd];
      w_dec = w_clr && r_pending[wb_addr] && !(w_set && (issue_rd == wb_addr));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
         r_cnt     <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_inc && !w_dec)      r_cnt <= r_cnt + CNT_ONE;
         else if (w_dec && !w_inc) r_cnt <= r_cnt - CNT_ONE;
      end
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_busy
      logic [ADDR_WIDTH-1:0] w_a;
      assign w_a = rs_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      // A same-cycle writeback to the source is forwarded, so it is not busy.
      assign rs_busy[gi] = (w_a != '0) && r_pending[w_a] && !(w_clr && (wb_addr == w_a));
   end

   assign pending_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with write-to-read bypass and issue scoreboard.
// Ports:
//   clk, reset (async, active low)
//   wb_en/wb_addr/wb_data : writeback; register 0 is never written
//   issue_en/issue_rd     : instruction issue, marks destination pending
//   rs_addr/rs_data       : NUM_READ combinational read ports, packed
//   rs_busy/hazard        : per-port pending flag and its OR
//   pending_cnt           : number of pending registers
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int NUM_READ   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wb_en,
   input  logic [ADDR_WIDTH-1:0]          wb_addr,
   input  logic [DATA_WIDTH-1:0]          wb_data,
   input  logic                           issue_en,
   input  logic [ADDR_WIDTH-1:0]          issue_rd,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rs_data,
   output logic [NUM_READ-1:0]            rs_busy,
   output logic                           hazard,
   output logic [ADDR_WIDTH:0]            pending_cnt
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_wr;

   assign w_wr = wb_en && (wb_addr != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else if (w_wr) begin
         r_mem[wb_addr] <= wb_data;
      end
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_a;
      assign w_a = rs_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rs_data[gi*DATA_WIDTH +: DATA_WIDTH] =
         (w_a == '0)                ? '0      :
         (w_wr && (wb_addr == w_a)) ? wb_data : r_mem[w_a];
   end

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_READ   (NUM_READ)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .rs_addr     (rs_addr),
      .rs_busy     (rs_busy),
      .pending_cnt (pending_cnt)
   );

   assign hazard = |rs_busy;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 2 ** AW;

   logic              clk = 1'b0;
   logic              reset;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [DW-1:0]     wb_data;
   logic              issue_en;
   logic [AW-1:0]     issue_rd;
   logic [NR*AW-1:0]  rs_addr;
   logic [NR*DW-1:0]  rs_data;
   logic [NR-1:0]     rs_busy;
   logic              hazard;
   logic [AW:0]       pending_cnt;

   int vecs = 0;
   int errs = 0;

   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];

   regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
      .clk(clk), .reset(reset), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .rs_addr(rs_addr), .rs_data(rs_data),
      .rs_busy(rs_busy), .hazard(hazard), .pending_cnt(pending_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_clear();
      for (int k = 0; k < DEPTH; k++) begin
         m_mem[k]  = '0;
         m_pend[k] = 1'b0;
      end
   endtask

   // Architectural effect of one clock edge: writeback retires, then issue claims.
   task automatic model_step();
      if (reset) begin
         if (wb_en && wb_addr != 0) begin
            m_mem[wb_addr]  = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(logic [AW-1:0] a);
      return (a != 0) && m_pend[a] && !(wb_en && wb_addr == a);
   endfunction

   function automatic logic [AW:0] exp_cnt();
      int n = 0;
      for (int k = 0; k < DEPTH; k++) n += int'(m_pend[k]);
      return (AW+1)'(n);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      issue_en = 1'b0; issue_rd = '0;
   endtask

   task automatic set_rs(int p, logic [AW-1:0] a);
      rs_addr[p*AW +: AW] = a;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      rs_addr = '0;
      reset = 1'b0;
      model_clear();
      // Strobes during reset must be ignored.
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hFFFF;
      issue_en = 1'b1; issue_rd = 5'd5;
      set_rs(0, 5'd5); set_rs(1, 5'd5);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      vecs++;
      if (pending_cnt !== '0 || rs_busy !== '0 || hazard !== 1'b0) begin
         errs++; $display("FAIL reset_during: cnt=%0d busy=%b hazard=%b want 0", pending_cnt, rs_busy, hazard);
      end
      idle();
      reset = 1'b1;
      #1;
      for (int p = 0; p < NR; p++) begin
         vecs++;
         if (rs_data[p*DW +: DW] !== '0 || rs_busy[p] !== 1'b0) begin
            errs++; $display("FAIL reset_read%0d: data=%h busy=%b want 0/0", p, rs_data[p*DW +: DW], rs_busy[p]);
         end
      end
      tick();
      vecs++;
      if (pending_cnt !== '0) begin
         errs++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt);
      end
   endtask

   task automatic test_r0_write();
      wb_en = 1'b1; wb_addr = '0; wb_data = 64'hDEAD;
      set_rs(0, '0);
      #1;
      vecs++;
      if (rs_data[0 +: DW] !== '0) begin
         errs++; $display("FAIL r0_same_cycle: got %h want 0", rs_data[0 +: DW]);
      end
      tick();
      idle();
      #1;
      vecs++;
      if (rs_data[0 +: DW] !== '0 || pending_cnt !== exp_cnt()) begin
         errs++; $display("FAIL r0_after: data=%h cnt=%0d want 0/%0d", rs_data[0 +: DW], pending_cnt, exp_cnt());
      end
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h1234;
      set_rs(0, 5'd7); set_rs(1, 5'd6);
      #1;
      vecs++;
      if (rs_data[0 +: DW] !== 64'h1234) begin
         errs++; $display("FAIL bypass_pre: got %h want 1234", rs_data[0 +: DW]);
      end
      vecs++;
      if (rs_data[DW +: DW] !== '0) begin
         errs++; $display("FAIL bypass_indep: got %h want 0", rs_data[DW +: DW]);
      end
      tick();
      idle();
      #1;
      vecs++;
      if (rs_data[0 +: DW] !== 64'h1234) begin
         errs++; $display("FAIL bypass_stored: got %h want 1234", rs_data[0 +: DW]);
      end
   endtask

   task automatic test_scoreboard();
      issue_en = 1'b1; issue_rd = 5'd3;
      tick();
      idle();
      set_rs(1, 5'd3); set_rs(0, 5'd7);
      #1;
      vecs++;
      if (rs_busy !== 2'b10 || hazard !== 1'b1 || pending_cnt !== 6'd1) begin
         errs++; $display("FAIL sb_pending: busy=%b hazard=%b cnt=%0d want 10/1/1", rs_busy, hazard, pending_cnt);
      end
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hAA;
      #1;
      vecs++;
      if (rs_busy[1] !== 1'b0 || hazard !== 1'b0 || rs_data[DW +: DW] !== 64'hAA) begin
         errs++; $display("FAIL sb_wb_bypass: busy1=%b hazard=%b data=%h want 0/0/aa", rs_busy[1], hazard, rs_data[DW +: DW]);
      end
      tick();
      idle();
      #1;
      vecs++;
      if (pending_cnt !== 6'd0 || rs_busy !== '0) begin
         errs++; $display("FAIL sb_retired: cnt=%0d busy=%b want 0/00", pending_cnt, rs_busy);
      end
   endtask

   task automatic test_same_cycle();
      issue_en = 1'b1; issue_rd = 5'd4;
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h55;
      tick();
      idle();
      set_rs(0, 5'd4);
      #1;
      vecs++;
      if (pending_cnt !== 6'd1 || rs_busy[0] !== 1'b1 || rs_data[0 +: DW] !== 64'h55) begin
         errs++; $display("FAIL same_new: cnt=%0d busy0=%b data=%h want 1/1/55", pending_cnt, rs_busy[0], rs_data[0 +: DW]);
      end
      // Already pending: set+clear on the same address is net zero.
      issue_en = 1'b1; issue_rd = 5'd4;
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h66;
      tick();
      // Re-issue to a pending register keeps it pending; wb to a non-pending one writes.
      issue_en = 1'b1; issue_rd = 5'd4;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h99;
      tick();
      idle();
      set_rs(1, 5'd9);
      #1;
      vecs++;
      if (pending_cnt !== 6'd1 || rs_busy !== 2'b01 || rs_data[DW +: DW] !== 64'h99 || rs_data[0 +: DW] !== 64'h66) begin
         errs++; $display("FAIL same_pending: cnt=%0d busy=%b d0=%h d1=%h want 1/01/66/99",
                          pending_cnt, rs_busy, rs_data[0 +: DW], rs_data[DW +: DW]);
      end
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h77;
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      issue_en = 1'b1; issue_rd = 5'd10;
      tick();
      issue_rd = 5'd11;
      wb_en = 1'b1; wb_addr = 5'd12; wb_data = 64'hBEEF;
      #2;
      reset = 1'b0;
      model_clear();
      set_rs(0, 5'd10); set_rs(1, 5'd7);
      #1;
      vecs++;
      if (pending_cnt !== '0 || rs_busy !== '0 || hazard !== 1'b0 || rs_data[DW +: DW] !== '0) begin
         errs++; $display("FAIL reset_async: cnt=%0d busy=%b hazard=%b d1=%h want all 0",
                          pending_cnt, rs_busy, hazard, rs_data[DW +: DW]);
      end
      @(posedge clk); @(negedge clk);
      idle();
      reset = 1'b1;
      set_rs(0, 5'd11); set_rs(1, 5'd12);
      #1;
      vecs++;
      if (pending_cnt !== '0 || rs_busy !== '0 || rs_data[DW +: DW] !== '0) begin
         errs++; $display("FAIL reset_release: cnt=%0d busy=%b d1=%h want 0/00/0", pending_cnt, rs_busy, rs_data[DW +: DW]);
      end
      issue_en = 1'b1; issue_rd = 5'd12;
      tick();
      idle();
      #1;
      vecs++;
      if (pending_cnt !== 6'd1 || rs_busy !== 2'b10) begin
         errs++; $display("FAIL reset_first_capture: cnt=%0d busy=%b want 1/10", pending_cnt, rs_busy);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int c = 0; c < 400; c++) begin
         wb_en    = 1'($urandom_range(0, 1));
         wb_addr  = AW'($urandom_range(0, 9));
         wb_data  = {$urandom, $urandom};
         issue_en = 1'($urandom_range(0, 1));
         issue_rd = AW'((c % 16 == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 9));
         for (int p = 0; p < NR; p++) set_rs(p, AW'($urandom_range(0, 10)));
         #1;
         for (int p = 0; p < NR; p++) begin
            a = rs_addr[p*AW +: AW];
            vecs++;
            if (rs_data[p*DW +: DW] !== exp_rd(a)) begin
               errs++; $display("FAIL rand_data c=%0d p=%0d a=%0d: got %h want %h", c, p, a, rs_data[p*DW +: DW], exp_rd(a));
            end
            vecs++;
            if (rs_busy[p] !== exp_busy(a)) begin
               errs++; $display("FAIL rand_busy c=%0d p=%0d a=%0d: got %b want %b", c, p, a, rs_busy[p], exp_busy(a));
            end
         end
         vecs++;
         if (hazard !== (exp_busy(rs_addr[0 +: AW]) | exp_busy(rs_addr[AW +: AW]))) begin
            errs++; $display("FAIL rand_hazard c=%0d: got %b", c, hazard);
         end
         tick();
         vecs++;
         if (pending_cnt !== exp_cnt()) begin
            errs++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, pending_cnt, exp_cnt());
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_r0_write();
      test_bypass();
      test_scoreboard();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
